// File: rtl/periph_bus.sv
// Single-master peripheral bus bridge: address-decodes one request at a time onto N_SLV slave
// ports, with an unmapped-slot error path and an ACCESS-phase timeout.
module periph_bus #(
  parameter int unsigned       N_SLV     = 9,
  parameter int unsigned       DEC_LSB   = 13,
  parameter int unsigned       DEC_W     = 4,
  parameter logic [N_SLV-1:0]  SLV_MASK  = 9'b1_1111_1101,
  parameter int unsigned       TIMEOUT   = 16,
  parameter logic [31:0]       ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_addr_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  output logic                  data_err_o,
  output logic [N_SLV-1:0]      slv_req_o,
  output logic                  slv_we_o,
  output logic [3:0]            slv_be_o,
  output logic [31:0]           slv_addr_o,
  output logic [31:0]           slv_wdata_o,
  input  logic [32*N_SLV-1:0]   slv_rdata_i,
  input  logic [N_SLV-1:0]      slv_ready_i
);

  localparam int unsigned CntW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DEC_W-1:0]  slot_q, slot_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [DEC_W-1:0]  req_slot;
  logic              req_mapped;
  logic              sel_ready;
  logic [31:0]       sel_rdata;
  logic [N_SLV-1:0]  sel_onehot;

  assign req_slot = data_addr_i[DEC_LSB +: DEC_W];

  // Slots at or above N_SLV never match, so they fall out as unmapped.
  always_comb begin
    req_mapped = 1'b0;
    sel_ready  = 1'b0;
    sel_rdata  = '0;
    sel_onehot = '0;
    for (int unsigned k = 0; k < N_SLV; k++) begin
      if (req_slot == DEC_W'(k)) begin
        req_mapped = SLV_MASK[k];
      end
      if (slot_q == DEC_W'(k)) begin
        sel_ready     = slv_ready_i[k];
        sel_rdata     = slv_rdata_i[32*k +: 32];
        sel_onehot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    slot_d     = slot_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    data_gnt_o = 1'b0;

    case (state_q)
      StIdle: begin
        data_gnt_o = data_req_i;
        if (data_req_i) begin
          we_d    = data_we_i;
          be_d    = data_be_i;
          addr_d  = data_addr_i;
          wdata_d = data_wdata_i;
          slot_d  = req_slot;
          cnt_d   = '0;
          if (req_mapped) begin
            state_d = StAccess;
          end else begin
            state_d = StResp;
            err_d   = 1'b1;
            rdata_d = ERR_RDATA;
          end
        end
      end
      StAccess: begin
        // Ready in the final counted cycle still completes without error.
        if (sel_ready) begin
          state_d = StResp;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : sel_rdata;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d = StResp;
          err_d   = 1'b1;
          rdata_d = ERR_RDATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      slot_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign data_rvalid_o = (state_q == StResp);
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;
  assign slv_req_o     = (state_q == StAccess) ? sel_onehot : '0;
  assign slv_we_o      = we_q;
  assign slv_be_o      = be_q;
  assign slv_addr_o    = addr_q;
  assign slv_wdata_o   = wdata_q;

endmodule

// File: tb/tb_periph_bus.sv
// Self-checking bench for periph_bus: vector table through a response scoreboard, plus
// hand sequences for back-to-back requests, response hold and mid-access reset.
module tb_periph_bus;

  localparam int unsigned NSlv = 9;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b0;
  logic                 data_req_i = 1'b0;
  logic                 data_we_i = 1'b0;
  logic [3:0]           data_be_i = '0;
  logic [31:0]          data_addr_i = '0;
  logic [31:0]          data_wdata_i = '0;
  logic                 data_gnt_o;
  logic                 data_rvalid_o;
  logic [31:0]          data_rdata_o;
  logic                 data_err_o;
  logic [NSlv-1:0]      slv_req_o;
  logic                 slv_we_o;
  logic [3:0]           slv_be_o;
  logic [31:0]          slv_addr_o;
  logic [31:0]          slv_wdata_o;
  logic [32*NSlv-1:0]   slv_rdata_i;
  logic [NSlv-1:0]      slv_ready_i = '0;

  periph_bus dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .data_req_i   (data_req_i),
    .data_we_i    (data_we_i),
    .data_be_i    (data_be_i),
    .data_addr_i  (data_addr_i),
    .data_wdata_i (data_wdata_i),
    .data_gnt_o   (data_gnt_o),
    .data_rvalid_o(data_rvalid_o),
    .data_rdata_o (data_rdata_o),
    .data_err_o   (data_err_o),
    .slv_req_o    (slv_req_o),
    .slv_we_o     (slv_we_o),
    .slv_be_o     (slv_be_o),
    .slv_addr_o   (slv_addr_o),
    .slv_wdata_o  (slv_wdata_o),
    .slv_rdata_i  (slv_rdata_i),
    .slv_ready_i  (slv_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic             we;
    logic [3:0]       be;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    int unsigned      d;      // ACCESS cycles until ready; 0 = never
    logic [NSlv-1:0]  sel;
    logic             err;
    logic [31:0]      rd;
    int unsigned      lat;    // grant-to-rvalid cycles
  } vec_t;

  typedef struct {
    logic [31:0]  rd;
    logic         err;
    int unsigned  at;
  } exp_t;

  exp_t sb[$];

  // Slave model state and expected latched fields of the current access
  logic [31:0]      slv_rd [NSlv];
  int unsigned      dly [NSlv];
  int unsigned      acnt [NSlv];
  logic [NSlv-1:0]  exp_sel = '0;
  logic             exp_we = 1'b0;
  logic [3:0]       exp_be = '0;
  logic [31:0]      exp_addr = '0;
  logic [31:0]      exp_wdata = '0;

  always_comb begin
    for (int k = 0; k < NSlv; k++) slv_rdata_i[32*k +: 32] = slv_rd[k];
  end

  // Slaves: selected one raises ready after dly cycles; others toggle randomly.
  always @(negedge clk_i) begin
    if (slv_req_o != '0) begin
      chk("slv_req_sel", 32'(slv_req_o), 32'(exp_sel));
      chk("slv_we_stable", 32'(slv_we_o), 32'(exp_we));
      chk("slv_be_stable", 32'(slv_be_o), 32'(exp_be));
      chk("slv_addr_stable", slv_addr_o, exp_addr);
      chk("slv_wdata_stable", slv_wdata_o, exp_wdata);
    end
    for (int k = 0; k < NSlv; k++) begin
      if (slv_req_o[k]) begin
        acnt[k]++;
        slv_ready_i[k] = (dly[k] != 0) && (acnt[k] == dly[k]);
      end else begin
        acnt[k] = 0;
        slv_ready_i[k] = 1'($urandom_range(0, 1));
      end
    end
  end

  // Response monitor: pops the scoreboard on each rvalid.
  always @(negedge clk_i) begin
    if (data_rvalid_o) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rvalid_unexpected: got rvalid=1 expected no response (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", data_rdata_o, e.rd);
        chk("rsp_err", 32'(data_err_o), 32'(e.err));
        chk("rsp_cycle", cyc, e.at);
      end
    end
  end

  task automatic set_inputs(input vec_t v);
    data_we_i    = v.we;
    data_be_i    = v.be;
    data_addr_i  = v.addr;
    data_wdata_i = v.wdata;
  endtask

  task automatic accept(input vec_t v);
    exp_sel   = v.sel;
    exp_we    = v.we;
    exp_be    = v.be;
    exp_addr  = v.addr;
    exp_wdata = v.wdata;
    sb.push_back('{rd: v.rd, err: v.err, at: cyc + v.lat});
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk_i);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d pending responses expected 0", nm, sb.size());
      sb.delete();
    end
    @(negedge clk_i);
  endtask

  task automatic issue(input vec_t v, input string nm);
    for (int k = 0; k < NSlv; k++) if (v.sel[k]) dly[k] = v.d;
    @(negedge clk_i);
    data_req_i = 1'b1;
    set_inputs(v);
    #1;
    chk({nm, "_gnt"}, 32'(data_gnt_o), 32'd1);
    accept(v);
    @(negedge clk_i);
    data_req_i = 1'b0;
    #1;
    chk({nm, "_slvreq_c1"}, 32'(slv_req_o), 32'(v.sel));
    drain(nm);
  endtask

  vec_t vecs[10];
  vec_t bb[3];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int idx;
    for (int k = 0; k < NSlv; k++) begin
      slv_rd[k] = 32'hA5A5_0000 | 32'(k);
      dly[k]    = 1;
      acnt[k]   = 0;
    end
    slv_rd[3] = 32'h1234_5678;

    //            we    be       addr           wdata          d   sel       err   rd             lat
    vecs[0] = '{1'b0, 4'hF, 32'h0000_6004, 32'h0,         1,  9'h008, 1'b0, 32'h1234_5678, 2};
    vecs[1] = '{1'b1, 4'hF, 32'h0000_2000, 32'h1111_2222, 1,  9'h000, 1'b1, 32'hDEAD_BEEF, 1};
    vecs[2] = '{1'b1, 4'h3, 32'h0001_0000, 32'hCAFE_F00D, 5,  9'h100, 1'b0, 32'h0,         6};
    vecs[3] = '{1'b0, 4'hF, 32'h0000_A000, 32'h0,         0,  9'h020, 1'b1, 32'hDEAD_BEEF, 17};
    vecs[4] = '{1'b0, 4'hF, 32'h0001_2000, 32'h0,         1,  9'h000, 1'b1, 32'hDEAD_BEEF, 1};
    vecs[5] = '{1'b0, 4'hF, 32'h0001_E000, 32'h0,         1,  9'h000, 1'b1, 32'hDEAD_BEEF, 1};
    vecs[6] = '{1'b0, 4'hF, 32'h0000_0008, 32'h0,         16, 9'h001, 1'b0, 32'hA5A5_0000, 17};
    vecs[7] = '{1'b0, 4'hF, 32'h0000_4000, 32'h0,         3,  9'h004, 1'b0, 32'hA5A5_0002, 4};
    vecs[8] = '{1'b1, 4'h8, 32'h0000_E00C, 32'h0BAD_F00D, 1,  9'h080, 1'b0, 32'h0,         2};
    vecs[9] = '{1'b0, 4'hF, 32'hFFF0_6004, 32'h0,         2,  9'h008, 1'b0, 32'h1234_5678, 3};

    bb[0] = '{1'b0, 4'hF, 32'h0000_0000, 32'h0, 1, 9'h001, 1'b0, 32'hA5A5_0000, 2};
    bb[1] = '{1'b0, 4'hF, 32'h0000_4000, 32'h0, 1, 9'h004, 1'b0, 32'hA5A5_0002, 2};
    bb[2] = '{1'b0, 4'hF, 32'h0000_0010, 32'h0, 1, 9'h001, 1'b0, 32'hA5A5_0000, 2};

    // Reset state
    #12;
    chk("rst_rvalid", 32'(data_rvalid_o), 32'd0);
    chk("rst_err", 32'(data_err_o), 32'd0);
    chk("rst_rdata", data_rdata_o, 32'd0);
    chk("rst_slv_req", 32'(slv_req_o), 32'd0);
    chk("rst_slv_we", 32'(slv_we_o), 32'd0);
    chk("rst_slv_be", 32'(slv_be_o), 32'd0);
    chk("rst_slv_addr", slv_addr_o, 32'd0);
    chk("rst_slv_wdata", slv_wdata_o, 32'd0);
    @(negedge clk_i);
    #2 rst_i = 1'b1;

    for (int i = 0; i < 10; i++) issue(vecs[i], $sformatf("vec%0d", i));

    // Request held high across three accesses: grants only from IDLE
    idx = 0;
    dly[0] = 1;
    dly[2] = 1;
    @(negedge clk_i);
    data_req_i = 1'b1;
    set_inputs(bb[0]);
    for (int c = 0; c < 40 && idx < 3; c++) begin
      #1;
      if (data_gnt_o) begin
        accept(bb[idx]);
        idx++;
      end
      @(posedge clk_i);
      #1;
      if (idx < 3) set_inputs(bb[idx]);
      else data_req_i = 1'b0;
      @(negedge clk_i);
      if (data_rvalid_o) chk("bb_gnt_in_resp", 32'(data_gnt_o), 32'd0);
      if (slv_req_o != '0) chk("bb_gnt_in_access", 32'(data_gnt_o), 32'd0);
    end
    data_req_i = 1'b0;
    chk("bb_grants", 32'(idx), 32'd3);
    drain("bb");

    // Error response data holds after rvalid drops
    issue(vecs[1], "hold");
    repeat (3) @(negedge clk_i);
    chk("hold_rdata", data_rdata_o, 32'hDEAD_BEEF);
    chk("hold_err", 32'(data_err_o), 32'd1);
    chk("hold_rvalid", 32'(data_rvalid_o), 32'd0);

    // Reset in mid-ACCESS aborts with no response
    dly[2] = 0;
    @(negedge clk_i);
    data_req_i = 1'b1;
    set_inputs(bb[1]);
    #1;
    chk("mid_gnt", 32'(data_gnt_o), 32'd1);
    exp_sel   = bb[1].sel;
    exp_we    = bb[1].we;
    exp_be    = bb[1].be;
    exp_addr  = bb[1].addr;
    exp_wdata = bb[1].wdata;
    @(negedge clk_i);
    data_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    chk("mid_rst_slv_req", 32'(slv_req_o), 32'd0);
    chk("mid_rst_rvalid", 32'(data_rvalid_o), 32'd0);
    chk("mid_rst_err", 32'(data_err_o), 32'd0);
    chk("mid_rst_rdata", data_rdata_o, 32'd0);
    chk("mid_rst_slv_addr", slv_addr_o, 32'd0);
    chk("mid_rst_slv_wdata", slv_wdata_o, 32'd0);
    chk("mid_rst_slv_be", 32'(slv_be_o), 32'd0);
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    repeat (20) @(negedge clk_i);

    issue(vecs[0], "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
